// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// MEM-stage data-memory access controller. It takes a load/store request from EX/MEM,
// runs it on a variable-latency req/ack data-memory port, and stalls the pipeline while
// the transaction is in flight. For loads it captures the returned word, the half-word
// select and the half-word flag for the downstream halfword extractor.
//
// Optional feature: define MEM_TIMEOUT_EN to enable the ack watchdog. After TIMEOUT REQ
// cycles with no ack, the transaction is aborted and bus_err pulses. With the macro
// undefined, REQ waits indefinitely and bus_err is tied to 0.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   mem_read/write     request from EX/MEM (both set = write)
//   half_word          1 = half-word access, 0 = word access
//   addr, wdata        byte address and store data
//   dm_req/we/addr/be  memory request, held stable until ack
//   dm_wdata           aligned store data
//   dm_ack, dm_rdata   memory acknowledge and read data
//   stall              freezes IF..EX/MEM (combinational)
//   ld_data/wc/half    captured load word, addr[1] and half flag (to the extractor)
//   ld_valid           one-cycle pulse when load data is updated
//   misalign           misaligned request flag (combinational)
//   bus_err            one-cycle pulse when the watchdog aborts a transaction
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        half_word,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_wc,
    output logic        ld_half,
    output logic        ld_valid,
    output logic        misalign,
    output logic        bus_err
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e      state_q, state_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        ld_wc_q, ld_wc_d;
    logic        ld_half_q, ld_half_d;
    logic        ld_valid_q, ld_valid_d;
    logic        bus_err_q, bus_err_d;

    logic        req_present;
    logic        req_misaligned;
    logic [3:0]  be_new;
    logic        timeout_hit;

    assign req_present    = mem_read | mem_write;
    assign req_misaligned = half_word ? addr[0] : (addr[1:0] != 2'b00);
    assign be_new         = !half_word ? 4'b1111 : (addr[1] ? 4'b1100 : 4'b0011);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts completed REQ cycles; zeroed whenever a transaction is issued.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StReq) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (state_q == StReq) && !dm_ack && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_be_d    = dm_be_q;
        dm_wdata_d = dm_wdata_q;
        ld_data_d  = ld_data_q;
        ld_wc_d    = ld_wc_q;
        ld_half_d  = ld_half_q;
        ld_valid_d = 1'b0;
        bus_err_d  = 1'b0;
        stall      = 1'b0;
        misalign   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_present) begin
                    if (req_misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        stall      = 1'b1;
                        state_d    = StReq;
                        dm_req_d   = 1'b1;
                        dm_we_d    = mem_write;
                        dm_addr_d  = {addr[31:2], 2'b00};
                        dm_be_d    = be_new;
                        dm_wdata_d = half_word ? {wdata[15:0], wdata[15:0]} : wdata;
                        // Stores must not disturb the extractor's select inputs.
                        if (!mem_write) begin
                            ld_wc_d   = addr[1];
                            ld_half_d = half_word;
                        end
                    end
                end
            end
            StReq: begin
                stall = 1'b1;
                if (dm_ack) begin
                    state_d  = StDone;
                    dm_req_d = 1'b0;
                    if (!dm_we_q) begin
                        ld_data_d  = dm_rdata;
                        ld_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d   = StDone;
                    dm_req_d  = 1'b0;
                    bus_err_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d  = StIdle;
                dm_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_be_q    <= '0;
            dm_wdata_q <= '0;
            ld_data_q  <= '0;
            ld_wc_q    <= 1'b0;
            ld_half_q  <= 1'b0;
            ld_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_be_q    <= dm_be_d;
            dm_wdata_q <= dm_wdata_d;
            ld_data_q  <= ld_data_d;
            ld_wc_q    <= ld_wc_d;
            ld_half_q  <= ld_half_d;
            ld_valid_q <= ld_valid_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_be    = dm_be_q;
    assign dm_wdata = dm_wdata_q;
    assign ld_data  = ld_data_q;
    assign ld_wc    = ld_wc_q;
    assign ld_half  = ld_half_q;
    assign ld_valid = ld_valid_q;
`ifdef MEM_TIMEOUT_EN
    assign bus_err  = bus_err_q;
`else
    assign bus_err  = 1'b0;
    logic unused_bus_err;
    assign unused_bus_err = bus_err_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: expected load results are pushed to a
// scoreboard when a request is driven and popped when the DONE cycle is reached.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 15;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        half_word = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_wc, ld_half, ld_valid, misalign, bus_err;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .half_word(half_word),
        .addr     (addr),
        .wdata    (wdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_be    (dm_be),
        .dm_wdata (dm_wdata),
        .dm_ack   (dm_ack),
        .dm_rdata (dm_rdata),
        .stall    (stall),
        .ld_data  (ld_data),
        .ld_wc    (ld_wc),
        .ld_half  (ld_half),
        .ld_valid (ld_valid),
        .misalign (misalign),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        wc;
        logic        half;
    } sb_t;

    sb_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Model of the held load state.
    logic [31:0] m_data = '0;
    logic        m_wc = 1'b0;
    logic        m_half = 1'b0;

    task automatic clear_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        half_word = 1'b0;
        addr      = '0;
        wdata     = '0;
    endtask

    // Runs one aligned access; ack is given in cycle lat (lat >= 1). Called at posedge+1
    // and returns at posedge+1 of the cycle after DONE with the request still applied.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic hw, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdat, input int lat);
        sb_t         e;
        sb_t         got;
        int          stalls;
        logic [3:0]  be;
        logic [31:0] wexp;
        logic        is_rd;
        is_rd = rd & ~wr;
        be    = !hw ? 4'b1111 : (a[1] ? 4'b1100 : 4'b0011);
        wexp  = hw ? {wd[15:0], wd[15:0]} : wd;
        if (is_rd) begin
            m_data = rdat;
            m_wc   = a[1];
            m_half = hw;
        end
        e.valid = is_rd;
        e.data  = m_data;
        e.wc    = m_wc;
        e.half  = m_half;
        sb.push_back(e);

        mem_read  = rd;
        mem_write = wr;
        half_word = hw;
        addr      = a;
        wdata     = wd;
        stalls    = 0;
        for (int c = 0; c <= lat; c++) begin
            dm_ack   = (c == lat);
            dm_rdata = (c == lat) ? rdat : $urandom();
            #1;
            if (stall) stalls++;
            if (c == 0) begin
                n_vec++;
                if ({misalign, dm_req} !== 2'b00) begin
                    n_err++;
                    $display("FAIL %s idle misalign/dm_req: got %b want 00", name,
                             {misalign, dm_req});
                end
            end
            if (c == 1) begin
                n_vec++;
                if ({dm_req, dm_we, dm_addr, dm_be} !== {1'b1, wr, a[31:2], 2'b00, be}) begin
                    n_err++;
                    $display("FAIL %s req fields: got req=%b we=%b addr=%h be=%b want %b %b %h %b",
                             name, dm_req, dm_we, dm_addr, dm_be, 1'b1, wr,
                             {a[31:2], 2'b00}, be);
                end
                if (wr) begin
                    n_vec++;
                    if (dm_wdata !== wexp) begin
                        n_err++;
                        $display("FAIL %s dm_wdata: got %h want %h", name, dm_wdata, wexp);
                    end
                end
            end
            if (c == lat && c > 1) begin
                n_vec++;
                if ({dm_req, dm_addr, dm_be} !== {1'b1, a[31:2], 2'b00, be}) begin
                    n_err++;
                    $display("FAIL %s req held: got req=%b addr=%h be=%b", name, dm_req,
                             dm_addr, dm_be);
                end
            end
            @(posedge clk);
            #1;
        end
        dm_ack   = 1'b0;
        dm_rdata = $urandom();
        #1;
        n_vec++;
        if ({dm_req, stall, bus_err} !== 3'b000) begin
            n_err++;
            $display("FAIL %s done req/stall/bus_err: got %b want 000", name,
                     {dm_req, stall, bus_err});
        end
        n_vec++;
        if (stalls !== lat + 1) begin
            n_err++;
            $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, lat + 1);
        end
        got = sb.pop_front();
        n_vec++;
        if (ld_valid !== got.valid) begin
            n_err++;
            $display("FAIL %s ld_valid: got %b want %b", name, ld_valid, got.valid);
        end
        n_vec++;
        if ({ld_data, ld_wc, ld_half} !== {got.data, got.wc, got.half}) begin
            n_err++;
            $display("FAIL %s ld state: got %h wc=%b half=%b want %h wc=%b half=%b", name,
                     ld_data, ld_wc, ld_half, got.data, got.wc, got.half);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (ld_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s ld_valid pulse width: got %b want 0", name, ld_valid);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata, ld_data, ld_wc, ld_half, ld_valid,
             bus_err, stall, misalign} !== '0) begin
            n_err++;
            $display("FAIL reset outputs: got req=%b we=%b addr=%h be=%b wd=%h ld=%h %b%b%b%b%b%b",
                     dm_req, dm_we, dm_addr, dm_be, dm_wdata, ld_data, ld_wc, ld_half,
                     ld_valid, bus_err, stall, misalign);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_load();
        do_access("word_load", 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1);
        clear_inputs();
    endtask

    task automatic test_half_store();
        do_access("half_store", 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 3);
        clear_inputs();
    endtask

    task automatic test_half_load_upper();
        logic [31:0] ext;
        do_access("half_load_up", 1'b1, 1'b0, 1'b1, 32'h0000_0206, 32'h0, 32'h8001_1234, 2);
        clear_inputs();
        // Reference halfword extractor applied to the captured load state.
        ext = ld_half ? (ld_wc ? {{16{ld_data[31]}}, ld_data[31:16]}
                               : {{16{ld_data[15]}}, ld_data[15:0]}) : ld_data;
        n_vec++;
        if (ext !== 32'hFFFF_8001) begin
            n_err++;
            $display("FAIL extractor result: got %h want ffff8001", ext);
        end
    endtask

    task automatic test_misaligned_one(input string name, input logic hw,
                                       input logic [31:0] a);
        mem_read  = 1'b1;
        half_word = hw;
        addr      = a;
        #1;
        n_vec++;
        if ({misalign, stall} !== 2'b10) begin
            n_err++;
            $display("FAIL %s misalign/stall: got %b want 10", name, {misalign, stall});
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({dm_req, ld_valid, stall} !== 3'b000) begin
                n_err++;
                $display("FAIL %s no-issue cycle %0d: got req/valid/stall %b want 000", name,
                         c, {dm_req, ld_valid, stall});
            end
        end
        n_vec++;
        if ({ld_data, ld_wc, ld_half} !== {m_data, m_wc, m_half}) begin
            n_err++;
            $display("FAIL %s ld state held: got %h %b %b want %h %b %b", name, ld_data,
                     ld_wc, ld_half, m_data, m_wc, m_half);
        end
        clear_inputs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_misaligned();
        test_misaligned_one("misalign_word", 1'b0, 32'h0000_0101);
        test_misaligned_one("misalign_half", 1'b1, 32'h0000_0103);
    endtask

    task automatic test_back_to_back();
        logic        rd, wr, hw;
        logic [31:0] a, wd, rdat;
        for (int i = 0; i < 10; i++) begin
            rd   = 1'($urandom_range(0, 1));
            wr   = ~rd;
            if (i == 3) begin
                rd = 1'b1;
                wr = 1'b1;
            end
            hw   = 1'($urandom_range(0, 1));
            a    = $urandom();
            a[0] = 1'b0;
            if (!hw) a[1] = 1'b0;
            wd   = $urandom();
            rdat = $urandom();
            do_access("back_to_back", rd, wr, hw, a, wd, rdat, $urandom_range(1, 4));
        end
        clear_inputs();
    endtask

    task automatic test_reset_in_req();
        mem_read  = 1'b1;
        half_word = 1'b1;
        addr      = 32'h0000_0302;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst      = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        m_data = '0;
        m_wc   = 1'b0;
        m_half = 1'b0;
        n_vec++;
        if ({dm_req, stall} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_in_req req/stall: got %b want 00", {dm_req, stall});
        end
        dm_ack   = 1'b1;
        dm_rdata = 32'h5555_5555;
        @(posedge clk);
        #1;
        dm_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_vec++;
            if ({ld_valid, dm_req, ld_data, ld_wc, ld_half} !== {2'b00, m_data, m_wc, m_half}) begin
                n_err++;
                $display("FAIL rst_in_req late ack: got valid=%b req=%b ld=%h %b %b want 0 0 %h",
                         ld_valid, dm_req, ld_data, ld_wc, ld_half, m_data);
            end
            @(posedge clk);
            #1;
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_watchdog();
        logic [31:0] held;
        held      = m_data;
        mem_read  = 1'b1;
        addr      = 32'h0000_0400;
        m_wc      = 1'b0;
        m_half    = 1'b0;
        for (int c = 0; c <= int'(TO); c++) begin
            #1;
            n_vec++;
            if ({stall, bus_err} !== 2'b10) begin
                n_err++;
                $display("FAIL watchdog wait cycle %0d: got stall/bus_err %b want 10", c,
                         {stall, bus_err});
            end
            @(posedge clk);
            #1;
            if (c == int'(TO)) clear_inputs();
        end
        n_vec++;
        if ({bus_err, stall, ld_valid, dm_req, ld_data} !== {4'b1000, held}) begin
            n_err++;
            $display("FAIL watchdog abort: got err=%b stall=%b valid=%b req=%b ld=%h want 1 0 0 0 %h",
                     bus_err, stall, ld_valid, dm_req, ld_data, held);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL watchdog pulse width: got %b want 0", bus_err);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_word_load();
        test_half_store();
        test_half_load_upper();
        test_misaligned();
        test_back_to_back();
        test_reset_in_req();
`ifdef MEM_TIMEOUT_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
